led_pwm_meter: RTL

//   Receive-side counterpart of the RGB LED driver: samples the three LED drive lines,

---
 rtl/led_pwm_meter_pkg.sv | 9 +
 rtl/led_pwm_meter_channel.sv | 55 +++++
 rtl/led_pwm_meter.sv | 71 +++++++
 3 files changed

// File: rtl/led_pwm_meter_pkg.sv
// Shared defaults and channel indices for the LED PWM meter.
package led_pkg;
    localparam int unsigned LED_FRAME_BITS_DEF  = 8;
    localparam int unsigned LED_SYNC_STAGES_DEF = 2;

    localparam int unsigned LED_R = 0;
    localparam int unsigned LED_G = 1;
    localparam int unsigned LED_B = 2;
endpackage

// File: rtl/led_pwm_meter_channel.sv
// One colour channel: input synchroniser, on-time accumulator and transition tracker.
module pwm_channel_meter
    import led_pkg::*;
#(
    parameter int unsigned FRAME_BITS  = LED_FRAME_BITS_DEF,
    parameter int unsigned SYNC_STAGES = LED_SYNC_STAGES_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_frame_end,
    input  logic                  i_line,
    output logic [FRAME_BITS:0]   o_duty,
    output logic                  o_steady
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   toggled_q;
    logic [FRAME_BITS:0]    acc_q;
    logic                   s_line;
    logic                   edge_now;
    logic [FRAME_BITS:0]    s_ext;

    assign s_line   = sync_q[SYNC_STAGES-1];
    assign edge_now = s_line != prev_q;
    assign s_ext    = {{FRAME_BITS{1'b0}}, s_line};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            toggled_q <= 1'b0;
            acc_q     <= '0;
            o_duty    <= '0;
            o_steady  <= 1'b0;
        end else begin
            sync_q[0] <= i_line;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            // prev persists across frames so a boundary edge lands in the new frame
            prev_q <= s_line;
            if (i_frame_end) begin
                o_duty    <= acc_q + s_ext;
                o_steady  <= ~(toggled_q | edge_now);
                acc_q     <= '0;
                toggled_q <= 1'b0;
            end else begin
                acc_q     <= acc_q + s_ext;
                toggled_q <= toggled_q | edge_now;
            end
        end
    end

endmodule

// File: rtl/led_pwm_meter.sv
// Frame counter and valid strobe around three per-colour duty meters.
module led_pwm_meter
    import led_pkg::*;
#(
    parameter int unsigned FRAME_BITS  = LED_FRAME_BITS_DEF,
    parameter int unsigned SYNC_STAGES = LED_SYNC_STAGES_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_led_r,
    input  logic                  i_led_g,
    input  logic                  i_led_b,
    output logic [FRAME_BITS:0]   o_duty_r,
    output logic [FRAME_BITS:0]   o_duty_g,
    output logic [FRAME_BITS:0]   o_duty_b,
    output logic [2:0]            o_steady,
    output logic                  o_valid
);

    logic [FRAME_BITS-1:0] frame_cnt_q;
    logic                  frame_end;

    assign frame_end = frame_cnt_q == '1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frame_cnt_q <= '0;
            o_valid     <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
            o_valid     <= frame_end;
        end
    end

    pwm_channel_meter #(
        .FRAME_BITS  (FRAME_BITS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_meter_r (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_frame_end (frame_end),
        .i_line      (i_led_r),
        .o_duty      (o_duty_r),
        .o_steady    (o_steady[LED_R])
    );

    pwm_channel_meter #(
        .FRAME_BITS  (FRAME_BITS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_meter_g (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_frame_end (frame_end),
        .i_line      (i_led_g),
        .o_duty      (o_duty_g),
        .o_steady    (o_steady[LED_G])
    );

    pwm_channel_meter #(
        .FRAME_BITS  (FRAME_BITS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_meter_b (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_frame_end (frame_end),
        .i_line      (i_led_b),
        .o_duty      (o_duty_b),
        .o_steady    (o_steady[LED_B])
    );

endmodule
